// File: rtl/mult_div_unit.sv
// Multicycle signed multiply/divide unit for MIPS mult/div.
// Radix-2 Booth multiply and restoring divide, one bit per clock into HI/LO.
module mult_div_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_mult,
  input  logic        start_div,
  input  logic [31:0] a_in,
  input  logic [31:0] b_in,
  output logic        busy,
  output logic        done,
  output logic        div_by_zero,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);

  typedef enum logic [1:0] {
    IDLE,
    MULT,
    DIV,
    FINISH
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [5:0]  cnt;
  logic [64:0] acc;
  logic [31:0] mcand;
  logic [32:0] rem;
  logic [32:0] dvsr;
  logic [31:0] quo;
  logic        is_div;
  logic        zero_div;
  logic        neg_q;
  logic        neg_r;

  logic        acc_mult;
  logic        acc_div;
  logic        last;
  logic [32:0] a_mag;
  logic [32:0] b_mag;
  logic [32:0] up_ext;
  logic [32:0] m_ext;
  logic [32:0] booth_sum;
  logic [64:0] acc_step;
  logic [32:0] trial;
  logic [32:0] diff;
  logic        ge;
  logic [31:0] q_fix;
  logic [31:0] r_fix;

  assign busy     = (state != IDLE);
  assign acc_mult = (state == IDLE) && start_mult;
  assign acc_div  = (state == IDLE) && !start_mult && start_div;
  assign last     = (cnt == 6'd31);

  // 33-bit magnitudes keep |-2^31| representable
  assign a_mag = a_in[31] ? 33'd0 - {a_in[31], a_in} : {1'b0, a_in};
  assign b_mag = b_in[31] ? 33'd0 - {b_in[31], b_in} : {1'b0, b_in};

  // Sum is kept 33 bits wide so the -2^31 multiplicand cannot overflow
  assign up_ext = {acc[64], acc[64:33]};
  assign m_ext  = {mcand[31], mcand};

  always_comb begin
    booth_sum = up_ext;
    unique case (acc[1:0])
      2'b01:   booth_sum = up_ext + m_ext;
      2'b10:   booth_sum = up_ext - m_ext;
      default: booth_sum = up_ext;
    endcase
  end

  assign acc_step = {booth_sum, acc[32:1]};

  assign trial = {rem[31:0], quo[31]};
  assign diff  = trial - dvsr;
  assign ge    = (trial >= dvsr);

  assign q_fix = neg_q ? 32'd0 - quo : quo;
  assign r_fix = neg_r ? 32'd0 - rem[31:0] : rem[31:0];

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (acc_mult)
          state_nx = MULT;
        else if (acc_div)
          state_nx = (b_in == 32'd0) ? FINISH : DIV;
      end
      MULT:    if (last) state_nx = FINISH;
      DIV:     if (last) state_nx = FINISH;
      FINISH:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt         <= '0;
      acc         <= '0;
      mcand       <= '0;
      rem         <= '0;
      dvsr        <= '0;
      quo         <= '0;
      is_div      <= 1'b0;
      zero_div    <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi_out      <= '0;
      lo_out      <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (acc_mult) begin
            acc         <= {32'd0, b_in, 1'b0};
            mcand       <= a_in;
            is_div      <= 1'b0;
            zero_div    <= 1'b0;
            div_by_zero <= 1'b0;
            cnt         <= '0;
          end else if (acc_div) begin
            rem         <= '0;
            quo         <= a_mag[31:0];
            dvsr        <= b_mag;
            neg_q       <= a_in[31] ^ b_in[31];
            neg_r       <= a_in[31];
            is_div      <= 1'b1;
            zero_div    <= (b_in == 32'd0);
            div_by_zero <= 1'b0;
            cnt         <= '0;
          end
        end
        MULT: begin
          acc <= acc_step;
          cnt <= last ? 6'd0 : cnt + 6'd1;
        end
        DIV: begin
          rem <= ge ? diff : trial;
          quo <= {quo[30:0], ge};
          cnt <= last ? 6'd0 : cnt + 6'd1;
        end
        FINISH: begin
          done <= 1'b1;
          if (zero_div) begin
            div_by_zero <= 1'b1;
          end else if (is_div) begin
            hi_out <= r_fix;
            lo_out <= q_fix;
          end else begin
            hi_out <= acc[64:33];
            lo_out <= acc[32:1];
          end
        end
        default: ;
      endcase
    end
  end

endmodule
